// File: rtl/vec_fetch_seq.sv
// Instruction fetch/decode sequencer for the vector generator: steps the PC through
// vector memory, decodes control-flow opcodes and hands draw words to the drawing engine.
module vec_fetch_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [15:0] mem_data,
    input  logic        vec_done,
    output logic        pc_rst,
    output logic        latch0,
    output logic        latch2,
    output logic        dmapush,
    output logic        dmaload,
    output logic        load_pc,
    output logic [11:0] count_in,
    output logic        vec_start,
    output logic [15:0] vec_word0,
    output logic [15:0] vec_word1,
    output logic        busy,
    output logic        halted,
    output logic        err
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_START  = 4'd1,
        S_WAIT0  = 4'd2,
        S_LATCH0 = 4'd3,
        S_WAIT1  = 4'd4,
        S_LATCH2 = 4'd5,
        S_EXEC   = 4'd6,
        S_PUSH   = 4'd7,
        S_LOAD   = 4'd8,
        S_POP    = 4'd9
    } state_t;

    localparam logic [2:0] STACK_FULL = 3'd4;

    state_t      state_q, state_d;
    logic [2:0]  depth_q, depth_d;
    logic        pc_rst_q, pc_rst_d;
    logic        latch0_q, latch0_d;
    logic        latch2_q, latch2_d;
    logic        dmapush_q, dmapush_d;
    logic        dmaload_q, dmaload_d;
    logic        load_pc_q, load_pc_d;
    logic [11:0] count_in_q, count_in_d;
    logic        vec_start_q, vec_start_d;
    logic [15:0] word0_q, word0_d;
    logic [15:0] word1_q, word1_d;
    logic        busy_q, busy_d;
    logic        halted_q, halted_d;
    logic        err_q, err_d;
    logic [3:0]  opcode_s;

    assign opcode_s = mem_data[15:12];

    // Next state plus next outputs; each strobe is raised on the edge that enters its state
    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        pc_rst_d    = 1'b0;
        latch0_d    = 1'b0;
        latch2_d    = 1'b0;
        dmapush_d   = 1'b0;
        dmaload_d   = 1'b0;
        load_pc_d   = 1'b0;
        count_in_d  = count_in_q;
        vec_start_d = 1'b0;
        word0_d     = word0_q;
        word1_d     = word1_q;
        halted_d    = halted_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d  = S_START;
                    pc_rst_d = 1'b1;
                    depth_d  = 3'd0;
                    halted_d = 1'b0;
                    err_d    = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: state_d = S_WAIT0;
            S_WAIT0: begin
                state_d  = S_LATCH0;
                latch0_d = 1'b1;
            end
            S_LATCH0: begin
                word0_d = mem_data;
                case (opcode_s)
                    4'hB: begin
                        state_d  = S_IDLE;
                        halted_d = 1'b1;
                    end
                    4'hC: begin
                        // Stack faults are caught here, before any push strobe is issued
                        if (depth_q == STACK_FULL) begin
                            state_d  = S_IDLE;
                            err_d    = 1'b1;
                            halted_d = 1'b1;
                        end else begin
                            state_d   = S_PUSH;
                            dmapush_d = 1'b1;
                        end
                    end
                    4'hD: begin
                        if (depth_q == 3'd0) begin
                            state_d  = S_IDLE;
                            err_d    = 1'b1;
                            halted_d = 1'b1;
                        end else begin
                            state_d   = S_POP;
                            dmaload_d = 1'b1;
                        end
                    end
                    4'hE: begin
                        state_d    = S_LOAD;
                        dmaload_d  = 1'b1;
                        load_pc_d  = 1'b1;
                        count_in_d = mem_data[11:0];
                    end
                    4'hF: begin
                        state_d     = S_EXEC;
                        word1_d     = 16'h0000;
                        vec_start_d = 1'b1;
                    end
                    default: state_d = S_WAIT1;
                endcase
            end
            S_WAIT1: begin
                state_d  = S_LATCH2;
                latch2_d = 1'b1;
            end
            S_LATCH2: begin
                word1_d     = mem_data;
                state_d     = S_EXEC;
                vec_start_d = 1'b1;
            end
            S_EXEC: begin
                if (vec_done) begin
                    state_d = S_WAIT0;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_PUSH: begin
                depth_d    = depth_q + 3'd1;
                state_d    = S_LOAD;
                dmaload_d  = 1'b1;
                load_pc_d  = 1'b1;
                count_in_d = word0_q[11:0];
            end
            S_LOAD: state_d = S_WAIT0;
            S_POP: begin
                depth_d = depth_q - 3'd1;
                state_d = S_WAIT0;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            depth_q     <= 3'd0;
            pc_rst_q    <= 1'b0;
            latch0_q    <= 1'b0;
            latch2_q    <= 1'b0;
            dmapush_q   <= 1'b0;
            dmaload_q   <= 1'b0;
            load_pc_q   <= 1'b0;
            count_in_q  <= 12'h000;
            vec_start_q <= 1'b0;
            word0_q     <= 16'h0000;
            word1_q     <= 16'h0000;
            busy_q      <= 1'b0;
            halted_q    <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            pc_rst_q    <= pc_rst_d;
            latch0_q    <= latch0_d;
            latch2_q    <= latch2_d;
            dmapush_q   <= dmapush_d;
            dmaload_q   <= dmaload_d;
            load_pc_q   <= load_pc_d;
            count_in_q  <= count_in_d;
            vec_start_q <= vec_start_d;
            word0_q     <= word0_d;
            word1_q     <= word1_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            err_q       <= err_d;
        end
    end

    assign pc_rst    = pc_rst_q;
    assign latch0    = latch0_q;
    assign latch2    = latch2_q;
    assign dmapush   = dmapush_q;
    assign dmaload   = dmaload_q;
    assign load_pc   = load_pc_q;
    assign count_in  = count_in_q;
    assign vec_start = vec_start_q;
    assign vec_word0 = word0_q;
    assign vec_word1 = word1_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign err       = err_q;

endmodule

// File: tb/tb_vec_fetch_seq.sv
// Bench for vec_fetch_seq: PC/stack/memory environment, an instruction-level reference
// model expanded into expected per-cycle strobes, directed scenarios and random programs.
module tb_vec_fetch_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic [15:0] mem_data;
    logic        vec_done = 1'b0;
    logic        pc_rst, latch0, latch2, dmapush, dmaload, load_pc, vec_start, busy, halted, err;
    logic [11:0] count_in;
    logic [15:0] vec_word0, vec_word1;

    vec_fetch_seq dut (
        .clk(clk), .reset(reset), .go(go), .mem_data(mem_data), .vec_done(vec_done),
        .pc_rst(pc_rst), .latch0(latch0), .latch2(latch2), .dmapush(dmapush),
        .dmaload(dmaload), .load_pc(load_pc), .count_in(count_in), .vec_start(vec_start),
        .vec_word0(vec_word0), .vec_word1(vec_word1), .busy(busy), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Environment: vector memory, PC counter and 4-entry PC stack driven by the strobes
    logic [15:0] mem [0:4095];
    logic [11:0] env_pc;
    logic [2:0]  env_sp;
    logic [11:0] env_stk [0:3];

    always @(posedge clk) begin
        mem_data <= mem[env_pc];
        if (reset || pc_rst) begin
            env_pc <= 12'd0;
            env_sp <= 3'd0;
        end else if (latch0 || latch2) begin
            env_pc <= env_pc + 12'd1;
        end else if (dmapush) begin
            env_stk[env_sp[1:0]] <= env_pc;
            env_sp <= env_sp + 3'd1;
        end else if (dmaload) begin
            if (load_pc) begin
                env_pc <= count_in;
            end else begin
                env_pc <= env_stk[env_sp[1:0] - 2'd1];
                env_sp <= env_sp - 3'd1;
            end
        end
    end

    // vec_done: random, or held low for 10 cycles after each vec_start when hold_on
    bit hold_on = 1'b0;
    int hold_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (hold_on && vec_start) hold_cnt = 10;
        if (hold_cnt > 0) begin
            vec_done = 1'b0;
            hold_cnt = hold_cnt - 1;
        end else begin
            vec_done = ($urandom_range(0, 2) == 0);
        end
    end

    // Reference model: one record per expected cycle, generated per instruction
    typedef struct packed {
        logic        is_start, pc_rst, latch0, latch2, dmapush, dmaload, load_pc;
        logic        exec, cont, stop, set_err, chk_pc;
        logic [11:0] pc;
        logic [11:0] cnt;
        logic [15:0] w0;
        logic [15:0] w1;
    } rec_t;

    rec_t        q[$];
    logic [11:0] m_stk[$];
    logic [11:0] m_pc = 12'd0;
    logic [11:0] m_cnt = 12'd0;
    bit          m_running = 1'b0;
    bit          m_halted = 1'b1;
    bit          m_err = 1'b0;
    rec_t        cr;
    int          n_pcrst = 0, n_push = 0, n_load = 0, n_vstart = 0;
    logic [15:0] last_w0 = 16'h0, last_w1 = 16'h0;

    task automatic interp();
        rec_t        r;
        logic [15:0] w0;
        logic [11:0] tgt;
        w0  = mem[m_pc];
        tgt = w0[11:0];
        r = '0;
        q.push_back(r);
        r = '0; r.latch0 = 1'b1; r.chk_pc = 1'b1; r.pc = m_pc;
        if (w0[15:12] <= 4'hA) begin
            q.push_back(r);
            r = '0; q.push_back(r);
            r = '0; r.latch2 = 1'b1; r.chk_pc = 1'b1; r.pc = m_pc + 12'd1; q.push_back(r);
            r = '0; r.exec = 1'b1; r.w0 = w0; r.w1 = mem[m_pc + 12'd1]; q.push_back(r);
            m_pc = m_pc + 12'd2;
        end else if (w0[15:12] == 4'hF) begin
            q.push_back(r);
            r = '0; r.exec = 1'b1; r.w0 = w0; r.w1 = 16'h0000; q.push_back(r);
            m_pc = m_pc + 12'd1;
        end else if (w0[15:12] == 4'hC) begin
            if (m_stk.size() == 4) begin
                r.stop = 1'b1; r.set_err = 1'b1; q.push_back(r);
            end else begin
                q.push_back(r);
                r = '0; r.dmapush = 1'b1; q.push_back(r);
                r = '0; r.dmaload = 1'b1; r.load_pc = 1'b1; r.cnt = tgt; q.push_back(r);
                m_stk.push_back(m_pc + 12'd1);
                m_pc = tgt;
            end
        end else if (w0[15:12] == 4'hD) begin
            if (m_stk.size() == 0) begin
                r.stop = 1'b1; r.set_err = 1'b1; q.push_back(r);
            end else begin
                q.push_back(r);
                r = '0; r.dmaload = 1'b1; r.load_pc = 1'b0; q.push_back(r);
                m_pc = m_stk.pop_back();
            end
        end else if (w0[15:12] == 4'hE) begin
            q.push_back(r);
            r = '0; r.dmaload = 1'b1; r.load_pc = 1'b1; r.cnt = tgt; q.push_back(r);
            m_pc = tgt;
        end else begin
            r.stop = 1'b1; q.push_back(r);
        end
    endtask

    // Per-cycle compare of every DUT output against the model
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            m_stk.delete();
            m_running = 1'b0;
            m_halted  = 1'b1;
            m_err     = 1'b0;
            m_cnt     = 12'd0;
        end else begin
            if (pc_rst) n_pcrst = n_pcrst + 1;
            if (dmapush) n_push = n_push + 1;
            if (dmaload) n_load = n_load + 1;
            if (vec_start) begin
                n_vstart = n_vstart + 1;
                last_w0  = vec_word0;
                last_w1  = vec_word1;
            end
            if (q.size() == 0 && m_running) interp();
            if (q.size() == 0) begin
                chk("idle_strobes", 32'({pc_rst, latch0, latch2, dmapush, dmaload, vec_start, busy}), 32'd0);
                chk("idle_status", 32'({halted, err}), 32'({m_halted, m_err}));
                chk("idle_count_in", 32'(count_in), 32'(m_cnt));
                if (go) begin
                    cr = '0; cr.is_start = 1'b1; cr.pc_rst = 1'b1;
                    q.push_back(cr);
                    m_running = 1'b1;
                    m_pc = 12'd0;
                    m_stk.delete();
                end
            end else begin
                cr = q[0];
                if (cr.is_start) begin
                    m_halted = 1'b0;
                    m_err    = 1'b0;
                end
                if (cr.dmaload && cr.load_pc) m_cnt = cr.cnt;
                chk("strobes", 32'({pc_rst, latch0, latch2, dmapush, dmaload, vec_start, busy}),
                    32'({cr.pc_rst, cr.latch0, cr.latch2, cr.dmapush, cr.dmaload, cr.exec && !cr.cont, 1'b1}));
                chk("run_status", 32'({halted, err}), 32'({m_halted, m_err}));
                chk("count_in", 32'(count_in), 32'(m_cnt));
                if (cr.dmaload) chk("load_pc", 32'(load_pc), 32'(cr.load_pc));
                if (cr.chk_pc) chk("fetch_addr", 32'(env_pc), 32'(cr.pc));
                if (cr.exec && !cr.cont) chk("vec_words", {vec_word0, vec_word1}, {cr.w0, cr.w1});
                if (cr.exec) begin
                    if (vec_done) begin
                        void'(q.pop_front());
                    end else begin
                        cr.cont = 1'b1;
                        q[0] = cr;
                    end
                end else begin
                    void'(q.pop_front());
                    if (cr.stop) begin
                        m_running = 1'b0;
                        m_halted  = 1'b1;
                        if (cr.set_err) m_err = 1'b1;
                    end
                end
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'hB000;
    endtask

    task automatic start_go();
        @(posedge clk);
        #1 go = 1'b1;
        repeat (3) @(posedge clk);
        #1 go = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            #1;
            if (!busy && q.size() == 0 && !m_running) done = 1'b1;
        end
        chk("run_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_sig(input bit on_push, input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(posedge clk);
            #1;
            seen = on_push ? dmapush : vec_start;
        end
        chk("event_timeout", 32'(seen), 32'd1);
    endtask

    task automatic pulse_reset_and_check();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_strobes", 32'({pc_rst, latch0, latch2, dmapush, dmaload, load_pc, vec_start, busy}), 32'd0);
        chk("rst_status", 32'({halted, err}), 32'd2);
        chk("rst_count_in", 32'(count_in), 32'd0);
        chk("rst_words", {vec_word0, vec_word1}, 32'd0);
    endtask

    task automatic gen_prog();
        int a, b, k;
        clear_mem();
        a = 0;
        for (int i = 0; i < $urandom_range(3, 12); i++) begin
            case ($urandom_range(0, 15))
                0, 1, 2, 3, 4: begin
                    mem[a] = {4'($urandom_range(0, 10)), 12'($urandom)};
                    mem[a + 1] = 16'($urandom);
                    a = a + 2;
                end
                5, 6, 7: begin mem[a] = {4'hF, 12'($urandom)}; a = a + 1; end
                8, 9, 10, 11: begin mem[a] = 16'hC200; a = a + 1; end
                12, 13, 14: begin
                    k = $urandom_range(1, 3);
                    mem[a] = {4'hE, 12'(a + 1 + k)};
                    a = a + 1 + k;
                end
                default: begin mem[a] = 16'hD000; a = a + 1; end
            endcase
        end
        mem[a] = 16'hB000;
        for (int s = 0; s < 5; s++) begin
            b = 512 + s * 64;
            mem[b] = {4'($urandom_range(0, 10)), 12'($urandom)};
            mem[b + 1] = 16'($urandom);
            b = b + 2;
            if (s < 4 && $urandom_range(0, 2) != 0) begin
                mem[b] = {4'hC, 12'(512 + (s + 1) * 64)};
                b = b + 1;
            end
            mem[b] = {4'hF, 12'($urandom)};
            mem[b + 1] = 16'hD000;
        end
    endtask

    int b_pcrst, b_push, b_load, b_vs;

    task automatic snap();
        b_pcrst = n_pcrst; b_push = n_push; b_load = n_load; b_vs = n_vstart;
    endtask

    initial begin
        clear_mem();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #1;
        chk("init_strobes", 32'({pc_rst, latch0, latch2, dmapush, dmaload, vec_start, busy}), 32'd0);
        chk("init_status", 32'({halted, err}), 32'd2);

        // Two-word draw then HALT
        mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'hB000;
        snap(); start_go(); wait_idle(500);
        chk("t1_word0", 32'(last_w0), 32'h1234);
        chk("t1_word1", 32'(last_w1), 32'h5678);
        chk("t1_vstarts", 32'(n_vstart - b_vs), 32'd1);
        chk("t1_halted_busy", 32'({halted, busy}), 32'd2);

        // JSR / SVEC / RTS / HALT
        clear_mem();
        mem[0] = 16'hC010; mem[1] = 16'hB000; mem[16] = 16'hF0AB; mem[17] = 16'hD000;
        snap(); start_go(); wait_idle(500);
        chk("t2_pushes", 32'(n_push - b_push), 32'd1);
        chk("t2_loads", 32'(n_load - b_load), 32'd2);
        chk("t2_count_in", 32'(count_in), 32'h010);
        chk("t2_svec_words", {last_w0, last_w1}, 32'hF0AB_0000);

        // Five nested JSRs: the fifth faults without pushing
        clear_mem();
        mem[0] = 16'hC010; mem[16] = 16'hC020; mem[32] = 16'hC030;
        mem[48] = 16'hC040; mem[64] = 16'hC050;
        snap(); start_go(); wait_idle(500);
        chk("t3_pushes", 32'(n_push - b_push), 32'd4);
        chk("t3_status", 32'({halted, err}), 32'd3);

        // RTS at depth 0, then a fresh go clears err
        clear_mem();
        mem[0] = 16'hD000;
        snap(); start_go(); wait_idle(500);
        chk("t4_loads", 32'(n_load - b_load), 32'd0);
        chk("t4_status", 32'({halted, err}), 32'd3);
        mem[0] = 16'hB000;
        snap(); start_go(); wait_idle(500);
        chk("t4_pc_rst", 32'(n_pcrst - b_pcrst), 32'd1);
        chk("t4_err_clear", 32'(err), 32'd0);

        // JMP to a VCTR with vec_done held off for 10 cycles
        clear_mem();
        mem[0] = 16'hE005; mem[5] = 16'h3111; mem[6] = 16'h2222; mem[7] = 16'hB000;
        hold_on = 1'b1;
        snap(); start_go(); wait_idle(500);
        hold_on = 1'b0;
        chk("t5_vstarts", 32'(n_vstart - b_vs), 32'd1);
        chk("t5_words", {last_w0, last_w1}, 32'h3111_2222);

        // Reset during EXEC, then restart from address 0
        clear_mem();
        mem[0] = 16'h1234; mem[1] = 16'h5678;
        hold_on = 1'b1;
        start_go(); wait_sig(1'b0, 100);
        pulse_reset_and_check();
        hold_on = 1'b0;
        mem[0] = 16'hF0AB;
        start_go(); wait_idle(500);

        // Reset during PUSH, then restart from address 0
        clear_mem();
        mem[0] = 16'hC010;
        start_go(); wait_sig(1'b1, 100);
        pulse_reset_and_check();
        mem[0] = 16'hF123;
        start_go(); wait_idle(500);

        // Random programs
        for (int t = 0; t < 25; t++) begin
            gen_prog();
            start_go();
            wait_idle(3000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vec_fetch_seq.md
# vec_fetch_seq

Instruction fetch/decode sequencer for the vector generator. Drives the program-counter control strobes: latch0, latch2, dmapush, dmaload, load_pc and the jump target. Captures instruction words from vector memory and hands draw instructions to the drawing engine. Runs programs from address 0 until HALT or a stack fault.

## Interface
- No parameters.
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- go  in  1  start request, sampled only in IDLE
- mem_data  in  16  vector memory read data; memory is addressed by PC count, synchronous read, valid 1 cycle after address change
- vec_done  in  1  drawing engine finished current instruction
- pc_rst  out  1  one-cycle pulse; top level ORs into PC reset (clears count and stack pointer)
- latch0  out  1  first-word capture; PC increments
- latch2  out  1  second-word capture; PC increments
- dmapush  out  1  push current PC onto PC stack
- dmaload  out  1  load PC (from count_in or stack)
- load_pc  out  1  with dmaload: 1 = load count_in, 0 = pop stack
- count_in  out  12  jump/call target
- vec_start  out  1  one-cycle strobe, vec_word0/1 valid
- vec_word0, vec_word1  out  16 each  captured instruction words
- busy  out  1  state != IDLE
- halted  out  1  sticky, set by HALT or fault, cleared on go
- err  out  1  sticky stack fault, cleared on go

## Operation
- Reset values: state IDLE, all strobes 0, count_in 0, vec_word0/1 0, depth 0, halted 1, err 0, busy 0.
- Opcode = word0[15:12]:
  - 0x0–0x9 VCTR and 0xA LABS: two words, draw.
  - 0xF SVEC: one word, draw.
  - 0xB HALT.
  - 0xC JSR, 0xD RTS, 0xE JMP: one word; target = word0[11:0].
- States and transitions:
  - IDLE: go=1 -> START.
  - START: pc_rst=1; clear depth, halted, err -> WAIT0.
  - WAIT0: no strobes; lets memory see the new PC -> LATCH0.
  - LATCH0: latch0=1; word0 <= mem_data.
    - VCTR/LABS -> WAIT1.
    - SVEC -> EXEC, word1 <= 0.
    - JSR -> PUSH, or IDLE with err/halted set if depth=4.
    - RTS -> POP, or IDLE with err/halted set if depth=0.
    - JMP -> LOAD.
    - HALT -> IDLE, halted=1.
  - WAIT1 -> LATCH2.
  - LATCH2: latch2=1; word1 <= mem_data -> EXEC.
  - EXEC: vec_start=1 on entry cycle only; remain until vec_done=1, then -> WAIT0.
  - PUSH: dmapush=1; depth+1 -> LOAD.
  - LOAD: dmaload=1, load_pc=1, count_in=word0[11:0] -> WAIT0.
  - POP: dmaload=1, load_pc=0; depth−1 -> WAIT0.
- The pushed return address is the PC after LATCH0, i.e. the instruction address + 1.
- Stack depth is 0..4, tracked locally to match the 4-entry PC stack. Faults are detected before any strobe, so no push or pop occurs on a fault.
- Strobes are decoded from state, so at most one of latch0/latch2/dmapush/dmaload is high per cycle. dmapush and dmaload are never adjacent to the same edge twice.
- count_in holds its last value outside LOAD.

## Timing
- go accepted (IDLE, go=1) -> pc_rst next cycle; first latch0 2 cycles after pc_rst.
- Per-instruction cycles from WAIT0 entry:
  - VCTR/LABS: 4 + EXEC cycles.
  - SVEC: 2 + EXEC.
  - JMP: 3. RTS: 3. JSR: 4. HALT: 2.
- EXEC minimum 1 cycle: vec_done high in the vec_start cycle advances immediately.
- vec_done outside EXEC is ignored. go outside IDLE is ignored.
- reset mid-operation: all state returns to reset values on that edge. Strobes deassert the same edge.

## Test plan
- Memory[0]=0x1234, [1]=0x5678, [2]=0xB000, go -> latch0 at PC 0, latch2 at PC 1, vec_start with word0=0x1234/word1=0x5678; vec_done -> HALT fetched; halted=1, busy=0.
- [0]=0xC010 JSR, [0x10]=0xF0AB, [0x11]=0xD000, [1]=0xB000 -> dmapush then dmaload/load_pc with count_in=0x010; SVEC drawn with word1=0; RTS pop returns PC to 1; halt.
- Five nested JSRs -> fifth faults: no dmapush, err=1, halted=1, depth stays 4.
- RTS at depth 0 -> err=1, no dmaload; next go clears err and pulses pc_rst.
- [0]=0xE005 JMP, vec_done held low for 10 cycles on VCTR at 5 -> single vec_start, latch strobes paused until vec_done.
- reset asserted during EXEC and during PUSH -> all outputs at reset values next cycle; go afterwards restarts at address 0.
